// File: rtl/ex_operand_stage.sv
// ID/EX operand stage feeding the execute ALU: one-entry register with
// EX/MEM and MEM/WB forwarding at capture, while held, and on the outputs.
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR-1:0]      in_rs1_addr,
  input  logic [REG_ADDR-1:0]      in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic                     in_alusrc,
  input  logic [OPCODE_LENGTH-1:0] in_operation,
  input  logic                     exmem_wr_en,
  input  logic                     memwb_wr_en,
  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_data,
  input  logic [DATA_WIDTH-1:0]    memwb_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    store_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                   state_q;
  logic [REG_ADDR-1:0]      rs1_addr_q, rs2_addr_q;
  logic [DATA_WIDTH-1:0]    rs1_val_q, rs2_val_q, imm_q;
  logic                     alusrc_q;
  logic [OPCODE_LENGTH-1:0] op_q;

  logic                     accept;
  logic [DATA_WIDTH-1:0]    in_rs1_fwd, in_rs2_fwd;
  logic [DATA_WIDTH-1:0]    rs1_fwd, rs2_fwd;

  // EX/MEM wins over MEM/WB; x0 is hard-wired and never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR-1:0]   addr,
    input logic [DATA_WIDTH-1:0] val,
    input logic                  ex_en,
    input logic [REG_ADDR-1:0]   ex_rd,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  wb_en,
    input logic [REG_ADDR-1:0]   wb_rd,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    if (addr != '0 && ex_en && ex_rd == addr) begin
      return ex_data;
    end else if (addr != '0 && wb_en && wb_rd == addr) begin
      return wb_data;
    end
    return val;
  endfunction

  assign in_rs1_fwd = fwd(in_rs1_addr, in_rs1_data, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
  assign in_rs2_fwd = fwd(in_rs2_addr, in_rs2_data, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
  assign rs1_fwd    = fwd(rs1_addr_q, rs1_val_q, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
  assign rs2_fwd    = fwd(rs2_addr_q, rs2_val_q, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);

  assign out_valid  = (state_q == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;

  assign SrcA       = rs1_fwd;
  assign store_data = rs2_fwd;
  assign SrcB       = alusrc_q ? imm_q : rs2_fwd;
  assign Operation  = op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      op_q       <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q    <= FULL;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rs1_val_q  <= in_rs1_fwd;
      rs2_val_q  <= in_rs2_fwd;
      imm_q      <= in_imm;
      alusrc_q   <= in_alusrc;
      op_q       <= in_operation;
    end else if (state_q == FULL && out_ready) begin
      state_q <= EMPTY;
    end else if (state_q == FULL) begin
      // Re-latch forwarded values so they survive the producer leaving WB.
      rs1_val_q <= rs1_fwd;
      rs2_val_q <= rs2_fwd;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: scoreboard model of the held
// entry plus directed per-feature scenarios.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alusrc;
  logic [3:0]  in_operation;
  logic        exmem_wr_en, memwb_wr_en;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] SrcA, SrcB, store_data;
  logic [3:0]  Operation;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  a1, a2;
    logic [31:0] v1, v2, imm;
    logic        alusrc;
    logic [3:0]  op;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_operation(in_operation),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .store_data(store_data)
  );

  function automatic logic [31:0] tb_fwd(input logic [4:0] a, input logic [31:0] v);
    if (a != 5'd0 && exmem_wr_en && exmem_rd == a) return exmem_data;
    if (a != 5'd0 && memwb_wr_en && memwb_rd == a) return memwb_data;
    return v;
  endfunction

  // Scoreboard: compare the head entry every valid cycle, then advance the model.
  always @(negedge clk) begin
    if (reset) begin
      ent_t        e;
      logic [31:0] ea, esd, eb;
      logic        mready;
      mready = (q.size() == 0) || out_ready;
      n_checks++;
      if (out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %0b expected %0b", out_valid, q.size() != 0);
      end
      n_checks++;
      if (in_ready !== mready) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %0b expected %0b", in_ready, mready);
      end
      if (q.size() != 0) begin
        e   = q[0];
        ea  = tb_fwd(e.a1, e.v1);
        esd = tb_fwd(e.a2, e.v2);
        eb  = e.alusrc ? e.imm : esd;
        n_checks++;
        if (SrcA !== ea) begin
          n_fail++;
          $display("FAIL sb_SrcA: got %h expected %h", SrcA, ea);
        end
        n_checks++;
        if (SrcB !== eb) begin
          n_fail++;
          $display("FAIL sb_SrcB: got %h expected %h", SrcB, eb);
        end
        n_checks++;
        if (store_data !== esd) begin
          n_fail++;
          $display("FAIL sb_store_data: got %h expected %h", store_data, esd);
        end
        n_checks++;
        if (Operation !== e.op) begin
          n_fail++;
          $display("FAIL sb_Operation: got %h expected %h", Operation, e.op);
        end
        if (flush || out_ready) begin
          void'(q.pop_front());
        end else begin
          q[0].v1 = ea;
          q[0].v2 = esd;
        end
      end
      if (!flush && in_valid && mready) begin
        e.a1 = in_rs1_addr;  e.a2 = in_rs2_addr;
        e.v1 = tb_fwd(in_rs1_addr, in_rs1_data);
        e.v2 = tb_fwd(in_rs2_addr, in_rs2_data);
        e.imm = in_imm; e.alusrc = in_alusrc; e.op = in_operation;
        q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic alusrc, input logic [3:0] op);
    in_valid = 1'b1;
    in_rs1_addr = a1; in_rs1_data = d1;
    in_rs2_addr = a2; in_rs2_data = d2;
    in_imm = imm; in_alusrc = alusrc; in_operation = op;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_alusrc = 1'b0; in_operation = '0;
  endtask

  task automatic clear_fwd;
    exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
    exmem_rd = '0; memwb_rd = '0;
    exmem_data = '0; memwb_data = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle(); clear_fwd();
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || SrcA !== 32'd0 || SrcB !== 32'd0 || store_data !== 32'd0 ||
        Operation !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b A=%h B=%h sd=%h op=%h rdy=%0b expected 0,0,0,0,0,1",
               out_valid, SrcA, SrcB, store_data, Operation, in_ready);
    end
    tick();
    reset = 1'b1;
    drive(5'd6, 32'h1111, 5'd7, 32'h2222, 32'h3, 1'b0, 4'b0011);
    tick();
    idle();
    #1;
    reset = 1'b0;
    q.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || SrcA !== 32'd0 || SrcB !== 32'd0 || Operation !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: valid=%0b A=%h B=%h op=%h expected 0,0,0,0",
               out_valid, SrcA, SrcB, Operation);
    end
    tick();
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    tick();
    out_ready = 1'b1;
    drive(5'd5, 32'd10, 5'd0, 32'd0, 32'd7, 1'b1, 4'b0010);
    tick();
    idle();
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || SrcA !== 32'd10 || SrcB !== 32'd7 || Operation !== 4'b0010) begin
      n_fail++;
      $display("FAIL basic_add: valid=%0b A=%0d B=%0d op=%b expected 1,10,7,0010",
               out_valid, SrcA, SrcB, Operation);
    end
    tick();
  endtask

  task automatic test_fwd_priority;
    exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAA;
    memwb_wr_en = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBB;
    drive(5'd3, 32'h1234, 5'd0, 32'd0, 32'd0, 1'b0, 4'b0000);
    tick();
    idle();
    #1;
    n_checks++;
    if (SrcA !== 32'hAA) begin
      n_fail++;
      $display("FAIL fwd_exmem_priority: got %h expected 000000aa", SrcA);
    end
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    drive(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 4'b1001);
    tick();
    idle();
    #1;
    n_checks++;
    if (SrcA !== 32'd0 || Operation !== 4'b1001) begin
      n_fail++;
      $display("FAIL fwd_x0: A=%h op=%b expected 00000000,1001", SrcA, Operation);
    end
    tick();
    clear_fwd();
  endtask

  task automatic test_hold_refresh;
    out_ready = 1'b0;
    drive(5'd1, 32'h5, 5'd4, 32'h11, 32'hFFFF, 1'b0, 4'b0011);
    tick();
    idle();
    memwb_wr_en = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h55;
    #1;
    n_checks++;
    if (SrcB !== 32'h55 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_cycle1: B=%h rdy=%0b expected 00000055,0", SrcB, in_ready);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      memwb_wr_en = 1'b0; memwb_data = 32'hDEAD;
      #1;
      n_checks++;
      if (SrcB !== 32'h55) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: B=%h expected 00000055", c, SrcB);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (SrcB !== 32'h55 || store_data !== 32'h55 || SrcA !== 32'h5) begin
      n_fail++;
      $display("FAIL hold_consume: A=%h B=%h sd=%h expected 5,55,55", SrcA, SrcB, store_data);
    end
    tick();
    clear_fwd();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_after_consume: valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(5'(i + 10), 32'(100 + i), 5'(i + 20), 32'(200 + i), 32'(i), 1'(i % 2), 4'(i));
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_valid_%0d: got %0b expected 1", i, out_valid);
      end
    end
    idle();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
    drive(5'd7, 32'h77, 5'd0, 32'd0, 32'd0, 1'b0, 4'b0000);
    tick();
    drive(5'd8, 32'h88, 5'd0, 32'd0, 32'd0, 1'b0, 4'b0001);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || SrcA !== 32'h77 || Operation !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rdy=%0b A=%h op=%b expected 0,77,0000",
                 c, in_ready, SrcA, Operation);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    idle();
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || SrcA !== 32'h88 || Operation !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_release: valid=%0b A=%h op=%b expected 1,88,0001",
               out_valid, SrcA, Operation);
    end
    tick();
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(5'd2, 32'h22, 5'd0, 32'd0, 32'd0, 1'b0, 4'b0010);
    tick();
    drive(5'd9, 32'h99, 5'd0, 32'd0, 32'd0, 1'b0, 4'b1000);
    flush = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: valid=%0b expected 1", out_valid);
    end
    tick();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || Operation === 4'b1000 || SrcA === 32'h99) begin
        n_fail++;
        $display("FAIL flush_post_%0d: valid=%0b op=%b A=%h expected 0, not 1000/99",
                 c, out_valid, Operation, SrcA);
      end
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: valid=%0b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_priority();
    test_hold_refresh();
    test_back_to_back();
    test_flush();
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries remain expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage placed directly upstream of the execute ALU. It registers one decoded instruction's operands and ALU operation code. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, both at capture and on every cycle the entry is held. It drives the ALU's SrcA, SrcB and Operation inputs through a valid/ready handshake with stall and flush support.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR, 5, register index width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (low) clears all state immediately
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rs1_addr, in_rs2_addr  in  REG_ADDR  source register indices
- in_rs1_data, in_rs2_data  in  DATA_WIDTH  register-file read values
- in_imm  in  DATA_WIDTH  sign-extended immediate
- in_alusrc  in  1  1 = SrcB takes immediate
- in_operation  in  OPCODE_LENGTH  ALU code (AND 0000, OR 0001, ADD 0010, SUB 0011, EQ 1000, XOR 1001)
- exmem_wr_en, memwb_wr_en  in  1  producer will write rd
- exmem_rd, memwb_rd  in  REG_ADDR  producer destination
- exmem_data, memwb_data  in  DATA_WIDTH  producer result
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  SrcA/SrcB/Operation are meaningful
- out_ready  in  1  execute consumes this cycle
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  registered ALU code
- store_data  out  DATA_WIDTH  forwarded rs2 value, independent of alusrc

## Operation
- Storage: one entry holding valid, rs1/rs2 addr, rs1/rs2 value, imm, alusrc, operation.
- Forward function fwd(addr, val): if addr != 0 and exmem_wr_en and exmem_rd == addr, return exmem_data; else if addr != 0 and memwb_wr_en and memwb_rd == addr, return memwb_data; else return val. EX/MEM has priority. x0 is never forwarded.
- Capture: on accept, store rs1 value = fwd(in_rs1_addr, in_rs1_data), rs2 value = fwd(in_rs2_addr, in_rs2_data), and store all other fields raw.
- Refresh: while out_valid and not out_ready, store rs1 value = fwd(stored rs1 addr, stored rs1 value) every cycle, and likewise for rs2. This keeps a forwarded value alive after its producer retires past WB.
- Outputs (combinational from stored state plus the current forward inputs):
  - SrcA = fwd(rs1 addr, rs1 value).
  - store_data = fwd(rs2 addr, rs2 value).
  - SrcB = alusrc ? imm : store_data.
  - Operation = stored code.
- Next-state priority: flush > accept > consume > hold.
  - flush: out_valid <= 0. Any concurrent incoming beat is discarded but counts as consumed upstream.
  - accept (in_valid & in_ready): load new entry and set out_valid <= 1. Back-to-back accept-and-consume in the same cycle is allowed.
  - consume without accept: out_valid <= 0.
  - hold: entry kept, refresh applied.
- States: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with consume.
  - FULL -> EMPTY on consume without accept, or on flush.
  - EMPTY stays EMPTY on flush.
- No arithmetic; data paths are pass-through at DATA_WIDTH with no truncation.

## Timing
- in_ready = !out_valid | out_ready. It has a combinational path from out_ready and is independent of flush.
- Latency: an instruction accepted at edge N is presented on SrcA/SrcB/Operation with out_valid = 1 after edge N.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Reset (low, asynchronous): out_valid = 0, all stored fields = 0, Operation = 0000, SrcA = SrcB = store_data = 0 (addr 0 never forwards). in_ready = 1.
- Reset mid-operation drops the held entry with no partial update. Deassertion is synchronized externally.
- Forward inputs sampled in the same cycle as a consume affect the consumed SrcA/SrcB.

## Test plan
- Reset low mid-stream with out_valid = 1: out_valid drops to 0 immediately and SrcA = SrcB = 0; after release, in_ready = 1.
- Accept ADD, rs1 = x5 with data 10, alusrc = 1, imm = 7, out_ready = 1: next cycle SrcA = 10, SrcB = 7, Operation = 0010, out_valid = 1.
- Both EX/MEM (rd = x3, data 0xAA) and MEM/WB (rd = x3, data 0xBB) match rs1 = x3: SrcA = 0xAA. Same match with rs1 = x0: SrcA equals the register-file value (0).
- Hold with out_ready = 0 for 3 cycles, MEM/WB writing x4 = 0x55 only in cycle 1, rs2 = x4, alusrc = 0: SrcB = 0x55 in cycles 1 through 3 and at consume.
- Back-to-back: 4 instructions with out_ready = 1 produce 4 consecutive out_valid cycles. With out_ready = 0 while FULL, in_ready = 0 and the held entry is unchanged.
- flush asserted together with in_valid while FULL: next cycle out_valid = 0, and the incoming instruction never appears at the output.
